// File: rtl/maptable_ckpt_pkg.sv
// Shared types and helpers for the checkpointed superscalar register map table.
// Holds the RAT entry and lookup packet layouts plus the per-entry update and lookup rules.
package maptable_ckpt_pkg;

  localparam int DISPATCH_W  = 2;
  localparam int WB_PORTS    = 2;
  localparam int NUM_CKPT    = 4;
  localparam int CKPT_W      = $clog2(NUM_CKPT);
  localparam int CNT_W       = CKPT_W + 1;
  localparam int ROB_TAG_LEN = 5;
  localparam int TAG_W       = ROB_TAG_LEN;
  localparam int NUM_REGS    = 32;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic             mapped;
    logic             ready;
    logic [TAG_W-1:0] tag;
  } rat_entry_t;

  typedef rat_entry_t [NUM_REGS-1:0] rat_table_t;

  typedef struct packed {
    logic             mapped;
    logic             rob_tag_ready;
    logic [TAG_W-1:0] rob_tag_val;
  } maptable_packet_t;

  typedef logic [WB_PORTS-1:0][4:0]       wb_rd_t;
  typedef logic [WB_PORTS-1:0][TAG_W-1:0] wb_tag_t;

  function automatic logic wb_hit(input logic [4:0] idx, input logic [TAG_W-1:0] tag,
                                  input logic [WB_PORTS-1:0] wb_valid, input wb_rd_t wb_rd,
                                  input wb_tag_t wb_tag);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      hit = hit | (wb_valid[p] && (wb_rd[p] == idx) && (wb_tag[p] == tag));
    end
    return hit;
  endfunction

  // Writeback first, then commit; a commit only clears a mapping that still names the retiring tag.
  function automatic rat_entry_t apply_wb_commit(input rat_entry_t e, input logic [4:0] idx,
                                                 input logic [WB_PORTS-1:0] wb_valid,
                                                 input wb_rd_t wb_rd, input wb_tag_t wb_tag,
                                                 input logic commit_valid,
                                                 input logic [4:0] commit_rd,
                                                 input logic [TAG_W-1:0] commit_tag);
    rat_entry_t n;
    logic       clr;
    n       = e;
    n.ready = e.ready | (e.mapped & wb_hit(idx, e.tag, wb_valid, wb_rd, wb_tag));
    clr     = commit_valid && e.mapped && (commit_rd == idx) && (commit_tag == e.tag);
    return clr ? rat_entry_t'('0) : n;
  endfunction

  function automatic maptable_packet_t lookup_entry(input rat_entry_t e, input logic [4:0] src,
                                                    input logic [WB_PORTS-1:0] wb_valid,
                                                    input wb_rd_t wb_rd, input wb_tag_t wb_tag);
    maptable_packet_t p;
    if ((src != ZERO_REG) && e.mapped) begin
      p.mapped        = 1'b1;
      p.rob_tag_ready = e.ready | wb_hit(src, e.tag, wb_valid, wb_rd, wb_tag);
      p.rob_tag_val   = e.tag;
    end else begin
      p = '0;
    end
    return p;
  endfunction

endpackage

// File: rtl/maptable_ckpt_chk.sv
// Protocol checker for the map table checkpoint FIFO.
module maptable_ckpt_chk
  import maptable_ckpt_pkg::*;
(
  input logic clock,
  input logic reset,
  input logic ckpt_take,
  input logic ckpt_full,
  input logic ckpt_release,
  input logic recover,
  input logic flush
);

  // A take into a full FIFO with no same-cycle release is dropped by the map table
  take_when_full: assert property (@(posedge clock) disable iff (reset)
    !(ckpt_take && ckpt_full && !ckpt_release && !recover && !flush))
    else $warning("maptable_ckpt: ckpt_take dropped, checkpoint FIFO full");

endmodule

// File: rtl/maptable_snapshot.sv
// One checkpoint bank of the map table: loadable copy that keeps tracking writebacks and commits.
module maptable_snapshot
  import maptable_ckpt_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  rat_table_t            load_data,
  input  logic [WB_PORTS-1:0]   wb_valid,
  input  wb_rd_t                wb_rd,
  input  wb_tag_t               wb_tag,
  input  logic                  commit_valid,
  input  logic [4:0]            commit_rd,
  input  logic [TAG_W-1:0]      commit_tag,
  output rat_table_t            entries
);

  rat_table_t upd;

  // Age the stored mappings with this cycle's writebacks and commits
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      upd[r] = apply_wb_commit(entries[r], 5'(r), wb_valid, wb_rd, wb_tag,
                               commit_valid, commit_rd, commit_tag);
    end
  end

  // Bank storage
  always_ff @(posedge clock) begin
    if (reset) begin
      entries <= '0;
    end else if (load) begin
      entries <= load_data;
    end else begin
      entries <= upd;
    end
  end

endmodule

// File: rtl/maptable_ckpt.sv
// Superscalar register map table with a FIFO of branch checkpoints for single-cycle mispredict recovery.
module maptable_ckpt
  import maptable_ckpt_pkg::*;
(
  input  logic                                clock,
  input  logic                                reset,
  input  logic [DISPATCH_W-1:0]               disp_valid,
  input  logic [DISPATCH_W-1:0][4:0]          disp_rs1,
  input  logic [DISPATCH_W-1:0][4:0]          disp_rs2,
  input  logic [DISPATCH_W-1:0][4:0]          disp_rd,
  input  logic [DISPATCH_W-1:0][TAG_W-1:0]    disp_tag,
  output maptable_packet_t [DISPATCH_W-1:0]   src1_pkt,
  output maptable_packet_t [DISPATCH_W-1:0]   src2_pkt,
  input  logic [WB_PORTS-1:0]                 wb_valid,
  input  wb_rd_t                              wb_rd,
  input  wb_tag_t                             wb_tag,
  input  logic                                commit_valid,
  input  logic [4:0]                          commit_rd,
  input  logic [TAG_W-1:0]                    commit_tag,
  input  logic                                ckpt_take,
  output logic [CKPT_W-1:0]                   ckpt_id,
  output logic                                ckpt_full,
  input  logic                                ckpt_release,
  input  logic                                recover,
  input  logic [CKPT_W-1:0]                   recover_id,
  input  logic                                flush
);

  rat_table_t            rat_q, rat_upd, rec_upd, rat_next;
  rat_table_t            snap [NUM_CKPT];
  logic [NUM_CKPT-1:0]   snap_load;
  logic [CKPT_W-1:0]     head_q, tail_q, head_next, tail_next, rec_keep;
  logic [CNT_W-1:0]      count_q, count_next;
  logic                  take_ok, rel_ok;

  assign ckpt_id  = tail_q;
  assign take_ok  = ckpt_take && (!ckpt_full || ckpt_release);
  assign rel_ok   = ckpt_release && (count_q != '0);
  assign rec_keep = recover_id - head_q;

  // Writeback/commit applied to the live table and to the snapshot chosen for recovery
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      rat_upd[r] = apply_wb_commit(rat_q[r], 5'(r), wb_valid, wb_rd, wb_tag,
                                   commit_valid, commit_rd, commit_tag);
      rec_upd[r] = apply_wb_commit(snap[recover_id][r], 5'(r), wb_valid, wb_rd, wb_tag,
                                   commit_valid, commit_rd, commit_tag);
    end
  end

  // Next live table; slots applied oldest first so the youngest writer of an rd wins
  always_comb begin
    rat_next = rat_upd;
    if (flush) begin
      rat_next = '0;
    end else if (recover) begin
      rat_next = rec_upd;
    end else begin
      for (int i = 0; i < DISPATCH_W; i++) begin
        rat_next[disp_rd[i]] = (disp_valid[i] && (disp_rd[i] != ZERO_REG))
                             ? rat_entry_t'{mapped: 1'b1, ready: 1'b0, tag: disp_tag[i]}
                             : rat_next[disp_rd[i]];
      end
    end
  end

  // Source lookup with writeback forwarding and intra-group bypass from older slots
  always_comb begin
    for (int j = 0; j < DISPATCH_W; j++) begin
      src1_pkt[j] = lookup_entry(rat_q[disp_rs1[j]], disp_rs1[j], wb_valid, wb_rd, wb_tag);
      src2_pkt[j] = lookup_entry(rat_q[disp_rs2[j]], disp_rs2[j], wb_valid, wb_rd, wb_tag);
      for (int i = 0; i < DISPATCH_W; i++) begin
        src1_pkt[j] = ((i < j) && disp_valid[i] && (disp_rd[i] != ZERO_REG) && (disp_rd[i] == disp_rs1[j]))
                    ? maptable_packet_t'{mapped: 1'b1, rob_tag_ready: 1'b0, rob_tag_val: disp_tag[i]}
                    : src1_pkt[j];
        src2_pkt[j] = ((i < j) && disp_valid[i] && (disp_rd[i] != ZERO_REG) && (disp_rd[i] == disp_rs2[j]))
                    ? maptable_packet_t'{mapped: 1'b1, rob_tag_ready: 1'b0, rob_tag_val: disp_tag[i]}
                    : src2_pkt[j];
      end
    end
  end

  // Checkpoint FIFO pointers; a recovery frees the recovered slot and everything younger
  always_comb begin
    head_next  = head_q;
    tail_next  = tail_q;
    count_next = count_q;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else if (recover) begin
      head_next  = (rec_keep == '0) ? recover_id : head_q + CKPT_W'(rel_ok);
      tail_next  = recover_id;
      count_next = {1'b0, rec_keep} - CNT_W'(rel_ok && (rec_keep != '0));
    end else begin
      head_next  = head_q + CKPT_W'(rel_ok);
      tail_next  = tail_q + CKPT_W'(take_ok);
      count_next = count_q + CNT_W'(take_ok) - CNT_W'(rel_ok);
    end
  end

  // Snapshot load strobes
  always_comb begin
    for (int k = 0; k < NUM_CKPT; k++) begin
      snap_load[k] = take_ok && !recover && !flush && (tail_q == CKPT_W'(k));
    end
  end

  // Live table and FIFO state
  always_ff @(posedge clock) begin
    if (reset) begin
      rat_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ckpt_full <= 1'b0;
    end else begin
      rat_q     <= rat_next;
      head_q    <= head_next;
      tail_q    <= tail_next;
      count_q   <= count_next;
      ckpt_full <= (count_next == CNT_W'(NUM_CKPT));
    end
  end

  for (genvar k = 0; k < NUM_CKPT; k++) begin : g_snap
    maptable_snapshot u_snap (
      .clock        (clock),
      .reset        (reset),
      .load         (snap_load[k]),
      .load_data    (rat_next),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_tag       (wb_tag),
      .commit_valid (commit_valid),
      .commit_rd    (commit_rd),
      .commit_tag   (commit_tag),
      .entries      (snap[k])
    );
  end

  maptable_ckpt_chk u_chk (
    .clock        (clock),
    .reset        (reset),
    .ckpt_take    (ckpt_take),
    .ckpt_full    (ckpt_full),
    .ckpt_release (ckpt_release),
    .recover      (recover),
    .flush        (flush)
  );

endmodule

// File: tb/tb_maptable_ckpt.sv
// Directed self-checking bench for maptable_ckpt: rename, bypass, writeback, checkpoints, recovery, flush.
module tb_maptable_ckpt;
  import maptable_ckpt_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [1:0]              disp_valid;
  logic [1:0][4:0]         disp_rs1, disp_rs2, disp_rd, disp_tag;
  maptable_packet_t [1:0]  src1_pkt, src2_pkt;
  logic [1:0]              wb_valid;
  wb_rd_t                  wb_rd;
  wb_tag_t                 wb_tag;
  logic                    commit_valid;
  logic [4:0]              commit_rd, commit_tag;
  logic                    ckpt_take, ckpt_full, ckpt_release, recover, flush;
  logic [1:0]              ckpt_id, recover_id;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  maptable_ckpt dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
    .disp_rd(disp_rd), .disp_tag(disp_tag),
    .src1_pkt(src1_pkt), .src2_pkt(src2_pkt),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .ckpt_release(ckpt_release), .recover(recover), .recover_id(recover_id),
    .flush(flush)
  );

  function automatic maptable_packet_t pk(input logic m, input logic r, input logic [4:0] t);
    return maptable_packet_t'{mapped: m, rob_tag_ready: r, rob_tag_val: t};
  endfunction

  task automatic idle();
    disp_valid = '0; disp_rs1 = '0; disp_rs2 = '0; disp_rd = '0; disp_tag = '0;
    wb_valid = '0; wb_rd = '0; wb_tag = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_tag = '0;
    ckpt_take = 1'b0; ckpt_release = 1'b0; recover = 1'b0; recover_id = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; tick(); tick(); reset = 1'b0;
    disp_rs1[0] = 5'd5; disp_rs2[1] = 5'd5; #1;
    checks++; if (src1_pkt[0] !== pk(1'b0, 1'b0, 5'd0)) begin failures++; $display("FAIL reset_lookup_r5: got %h expected %h", src1_pkt[0], pk(1'b0, 1'b0, 5'd0)); end
    checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", ckpt_full); end
    checks++; if (ckpt_id !== 2'd0) begin failures++; $display("FAIL reset_id: got %0d expected 0", ckpt_id); end
  endtask

  task automatic test_dispatch();
    idle(); disp_valid = 2'b01; disp_rd[0] = 5'd5; disp_tag[0] = 5'd3; disp_rs1[0] = 5'd5; #1;
    checks++; if (src1_pkt[0] !== pk(1'b0, 1'b0, 5'd0)) begin failures++; $display("FAIL no_self_bypass: got %h expected %h", src1_pkt[0], pk(1'b0, 1'b0, 5'd0)); end
    tick(); idle(); disp_rs1[0] = 5'd5; disp_rs2[1] = 5'd5; #1;
    checks++; if (src1_pkt[0] !== pk(1'b1, 1'b0, 5'd3)) begin failures++; $display("FAIL dispatch_r5_s1: got %h expected %h", src1_pkt[0], pk(1'b1, 1'b0, 5'd3)); end
    checks++; if (src2_pkt[1] !== pk(1'b1, 1'b0, 5'd3)) begin failures++; $display("FAIL dispatch_r5_s2: got %h expected %h", src2_pkt[1], pk(1'b1, 1'b0, 5'd3)); end
  endtask

  task automatic test_bypass();
    idle(); disp_valid = 2'b11; disp_rd[0] = 5'd7; disp_tag[0] = 5'd4;
    disp_rs1[1] = 5'd7; disp_rd[1] = 5'd7; disp_tag[1] = 5'd5; #1;
    checks++; if (src1_pkt[1] !== pk(1'b1, 1'b0, 5'd4)) begin failures++; $display("FAIL bypass_slot1: got %h expected %h", src1_pkt[1], pk(1'b1, 1'b0, 5'd4)); end
    tick(); idle(); disp_rs1[0] = 5'd7; #1;
    checks++; if (src1_pkt[0] !== pk(1'b1, 1'b0, 5'd5)) begin failures++; $display("FAIL younger_wins_r7: got %h expected %h", src1_pkt[0], pk(1'b1, 1'b0, 5'd5)); end
    idle(); disp_valid = 2'b01; disp_rd[0] = 5'd0; disp_tag[0] = 5'd9; disp_rs1[1] = 5'd0; #1;
    checks++; if (src1_pkt[1] !== pk(1'b0, 1'b0, 5'd0)) begin failures++; $display("FAIL zero_reg_bypass: got %h expected %h", src1_pkt[1], pk(1'b0, 1'b0, 5'd0)); end
    tick(); idle(); disp_rs1[0] = 5'd0; #1;
    checks++; if (src1_pkt[0] !== pk(1'b0, 1'b0, 5'd0)) begin failures++; $display("FAIL zero_reg_table: got %h expected %h", src1_pkt[0], pk(1'b0, 1'b0, 5'd0)); end
  endtask

  task automatic test_wb();
    idle(); disp_valid = 2'b01; disp_rd[0] = 5'd2; disp_tag[0] = 5'd6; tick();
    idle(); disp_rs1[0] = 5'd2; wb_valid = 2'b10; wb_rd[1] = 5'd2; wb_tag[1] = 5'd6; #1;
    checks++; if (src1_pkt[0] !== pk(1'b1, 1'b1, 5'd6)) begin failures++; $display("FAIL wb_forward: got %h expected %h", src1_pkt[0], pk(1'b1, 1'b1, 5'd6)); end
    tick(); idle(); disp_rs1[0] = 5'd2; #1;
    checks++; if (src1_pkt[0] !== pk(1'b1, 1'b1, 5'd6)) begin failures++; $display("FAIL wb_held: got %h expected %h", src1_pkt[0], pk(1'b1, 1'b1, 5'd6)); end
    idle(); disp_valid = 2'b01; disp_rd[0] = 5'd9; disp_tag[0] = 5'd10; tick();
    idle(); disp_rs1[0] = 5'd9; wb_valid = 2'b01; wb_rd[0] = 5'd9; wb_tag[0] = 5'd9; #1;
    checks++; if (src1_pkt[0] !== pk(1'b1, 1'b0, 5'd10)) begin failures++; $display("FAIL stale_wb_fwd: got %h expected %h", src1_pkt[0], pk(1'b1, 1'b0, 5'd10)); end
    tick(); idle(); disp_rs1[0] = 5'd9; #1;
    checks++; if (src1_pkt[0] !== pk(1'b1, 1'b0, 5'd10)) begin failures++; $display("FAIL stale_wb_table: got %h expected %h", src1_pkt[0], pk(1'b1, 1'b0, 5'd10)); end
  endtask

  task automatic test_recover();
    idle(); disp_valid = 2'b01; disp_rd[0] = 5'd3; disp_tag[0] = 5'd1; ckpt_take = 1'b1; #1;
    checks++; if (ckpt_id !== 2'd0) begin failures++; $display("FAIL take_id0: got %0d expected 0", ckpt_id); end
    tick(); idle(); disp_valid = 2'b01; disp_rd[0] = 5'd3; disp_tag[0] = 5'd2; tick();
    idle(); disp_rs1[0] = 5'd3; wb_valid = 2'b01; wb_rd[0] = 5'd3; wb_tag[0] = 5'd1; #1;
    checks++; if (src1_pkt[0] !== pk(1'b1, 1'b0, 5'd2)) begin failures++; $display("FAIL r3_young: got %h expected %h", src1_pkt[0], pk(1'b1, 1'b0, 5'd2)); end
    tick(); idle(); recover = 1'b1; recover_id = 2'd0; disp_valid = 2'b01; disp_rd[0] = 5'd11; disp_tag[0] = 5'd12; tick();
    idle(); disp_rs1[0] = 5'd3; disp_rs1[1] = 5'd7; disp_rs2[0] = 5'd11; #1;
    checks++; if (src1_pkt[0] !== pk(1'b1, 1'b1, 5'd1)) begin failures++; $display("FAIL recover_r3: got %h expected %h", src1_pkt[0], pk(1'b1, 1'b1, 5'd1)); end
    checks++; if (src1_pkt[1] !== pk(1'b1, 1'b0, 5'd5)) begin failures++; $display("FAIL recover_r7: got %h expected %h", src1_pkt[1], pk(1'b1, 1'b0, 5'd5)); end
    checks++; if (src2_pkt[0] !== pk(1'b0, 1'b0, 5'd0)) begin failures++; $display("FAIL recover_drops_disp: got %h expected %h", src2_pkt[0], pk(1'b0, 1'b0, 5'd0)); end
  endtask

  task automatic test_ckpt_fifo();
    // count is 0 after the recovery: three takes leave the FIFO short of full, the fourth fills it
    for (int k = 0; k < 4; k++) begin
      idle(); ckpt_take = 1'b1; #1;
      checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL fill_not_full_%0d: got %b expected 0", k, ckpt_full); end
      tick();
    end
    checks++; if (ckpt_full !== 1'b1) begin failures++; $display("FAIL fill_full: got %b expected 1", ckpt_full); end
    idle(); ckpt_take = 1'b1; tick(); idle(); #1;
    checks++; if (ckpt_full !== 1'b1) begin failures++; $display("FAIL fifth_take_full: got %b expected 1", ckpt_full); end
    idle(); flush = 1'b1; tick(); idle(); #1;
    checks++; if (ckpt_id !== 2'd0) begin failures++; $display("FAIL flush_id: got %0d expected 0", ckpt_id); end
    for (int k = 0; k < 4; k++) begin
      idle(); ckpt_take = 1'b1; #1;
      checks++; if (ckpt_id !== 2'(k)) begin failures++; $display("FAIL fifo_id_%0d: got %0d expected %0d", k, ckpt_id, k); end
      tick();
    end
    idle(); ckpt_take = 1'b1; ckpt_release = 1'b1; #1;
    checks++; if (ckpt_id !== 2'd0) begin failures++; $display("FAIL wrap_id: got %0d expected 0", ckpt_id); end
    tick(); idle(); #1;
    checks++; if (ckpt_full !== 1'b1) begin failures++; $display("FAIL rel_take_full: got %b expected 1", ckpt_full); end
    checks++; if (ckpt_id !== 2'd1) begin failures++; $display("FAIL rel_take_id: got %0d expected 1", ckpt_id); end
    idle(); ckpt_release = 1'b1; tick(); idle(); #1;
    checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL release_full: got %b expected 0", ckpt_full); end
  endtask

  task automatic test_commit_flush();
    idle(); disp_valid = 2'b11; disp_rd[0] = 5'd4; disp_tag[0] = 5'd0; disp_rd[1] = 5'd6; disp_tag[1] = 5'd8; ckpt_take = 1'b1; #1;
    checks++; if (ckpt_id !== 2'd1) begin failures++; $display("FAIL take_r4_id: got %0d expected 1", ckpt_id); end
    tick(); idle(); commit_valid = 1'b1; commit_rd = 5'd4; commit_tag = 5'd0; tick();
    idle(); disp_rs1[0] = 5'd4; disp_rs1[1] = 5'd6; #1;
    checks++; if (src1_pkt[0] !== pk(1'b0, 1'b0, 5'd0)) begin failures++; $display("FAIL commit_r4: got %h expected %h", src1_pkt[0], pk(1'b0, 1'b0, 5'd0)); end
    checks++; if (src1_pkt[1] !== pk(1'b1, 1'b0, 5'd8)) begin failures++; $display("FAIL live_r6: got %h expected %h", src1_pkt[1], pk(1'b1, 1'b0, 5'd8)); end
    idle(); disp_valid = 2'b01; disp_rd[0] = 5'd4; disp_tag[0] = 5'd13; tick();
    idle(); recover = 1'b1; recover_id = 2'd1; tick();
    idle(); disp_rs1[0] = 5'd4; disp_rs1[1] = 5'd6; commit_valid = 1'b1; commit_rd = 5'd6; commit_tag = 5'd7; #1;
    checks++; if (src1_pkt[0] !== pk(1'b0, 1'b0, 5'd0)) begin failures++; $display("FAIL snap_commit_r4: got %h expected %h", src1_pkt[0], pk(1'b0, 1'b0, 5'd0)); end
    checks++; if (src1_pkt[1] !== pk(1'b1, 1'b0, 5'd8)) begin failures++; $display("FAIL snap_r6: got %h expected %h", src1_pkt[1], pk(1'b1, 1'b0, 5'd8)); end
    checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL recover_full: got %b expected 0", ckpt_full); end
    tick(); idle(); disp_rs1[1] = 5'd6; #1;
    checks++; if (src1_pkt[1] !== pk(1'b1, 1'b0, 5'd8)) begin failures++; $display("FAIL stale_commit_r6: got %h expected %h", src1_pkt[1], pk(1'b1, 1'b0, 5'd8)); end
    idle(); flush = 1'b1; recover = 1'b1; recover_id = 2'd1; ckpt_take = 1'b1;
    disp_valid = 2'b01; disp_rd[0] = 5'd5; disp_tag[0] = 5'd2; tick();
    idle(); disp_rs1[0] = 5'd6; disp_rs1[1] = 5'd5; #1;
    checks++; if (src1_pkt[0] !== pk(1'b0, 1'b0, 5'd0)) begin failures++; $display("FAIL flush_r6: got %h expected %h", src1_pkt[0], pk(1'b0, 1'b0, 5'd0)); end
    checks++; if (src1_pkt[1] !== pk(1'b0, 1'b0, 5'd0)) begin failures++; $display("FAIL flush_r5: got %h expected %h", src1_pkt[1], pk(1'b0, 1'b0, 5'd0)); end
    checks++; if (ckpt_full !== 1'b0) begin failures++; $display("FAIL flush_full: got %b expected 0", ckpt_full); end
    checks++; if (ckpt_id !== 2'd0) begin failures++; $display("FAIL flush_fifo_id: got %0d expected 0", ckpt_id); end
  endtask

  task automatic test_back_to_back();
    idle(); disp_valid = 2'b11; disp_rd[0] = 5'd10; disp_tag[0] = 5'd11;
    disp_rd[1] = 5'd12; disp_tag[1] = 5'd14; disp_rs1[1] = 5'd10; #1;
    checks++; if (src1_pkt[1] !== pk(1'b1, 1'b0, 5'd11)) begin failures++; $display("FAIL b2b_bypass: got %h expected %h", src1_pkt[1], pk(1'b1, 1'b0, 5'd11)); end
    tick(); idle(); disp_valid = 2'b01; disp_rd[0] = 5'd10; disp_tag[0] = 5'd15; disp_rs1[0] = 5'd10;
    disp_rs2[1] = 5'd12; wb_valid = 2'b01; wb_rd[0] = 5'd12; wb_tag[0] = 5'd14; #1;
    checks++; if (src1_pkt[0] !== pk(1'b1, 1'b0, 5'd11)) begin failures++; $display("FAIL b2b_table_r10: got %h expected %h", src1_pkt[0], pk(1'b1, 1'b0, 5'd11)); end
    checks++; if (src2_pkt[1] !== pk(1'b1, 1'b1, 5'd14)) begin failures++; $display("FAIL b2b_wb_r12: got %h expected %h", src2_pkt[1], pk(1'b1, 1'b1, 5'd14)); end
    tick(); idle(); disp_rs1[0] = 5'd10; disp_rs2[0] = 5'd12; #1;
    checks++; if (src1_pkt[0] !== pk(1'b1, 1'b0, 5'd15)) begin failures++; $display("FAIL b2b_r10_next: got %h expected %h", src1_pkt[0], pk(1'b1, 1'b0, 5'd15)); end
    checks++; if (src2_pkt[0] !== pk(1'b1, 1'b1, 5'd14)) begin failures++; $display("FAIL b2b_r12_next: got %h expected %h", src2_pkt[0], pk(1'b1, 1'b1, 5'd14)); end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_bypass();
    test_wb();
    test_recover();
    test_ckpt_fifo();
    test_commit_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
